// File: rtl/riscv_writeback_stage.sv
// Writeback stage: result select, load extract, GPR write strobe.
// Optional retired-instruction counter behind RISCV_WB_INSTRET_EN.
module riscv_writeback_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [1:0]            mem_wb_sel,
  input  logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_pc_plus4,
  input  logic [DATA_W-1:0]     mem_imm,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0]     reg_write_data
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0]           instret
`endif
);

  typedef enum logic {IDLE, WAIT_LOAD} state_e;

  state_e                  state_q, state_d;
  logic                    rd_we_q, rd_we_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic                    en_q, en_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]       data_q, data_d;

  logic              xfer;
  logic              is_load;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] nl_data;

  assign mem_ready = (state_q == IDLE) && !rst;
  assign xfer      = mem_valid && mem_ready;
  assign is_load   = (mem_wb_sel == 2'b01);

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    unique case (off_q)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_comb begin
    nl_data = mem_alu_result;
    unique case (mem_wb_sel)
      2'b10:   nl_data = mem_pc_plus4;
      2'b11:   nl_data = mem_imm;
      default: nl_data = mem_alu_result;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rd_we_d  = rd_we_q;
    rd_d     = rd_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    en_d     = 1'b0;
    dest_d   = dest_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (xfer && is_load) begin
          rd_we_d  = mem_rd_we;
          rd_d     = mem_rd;
          funct3_d = mem_funct3;
          off_d    = mem_alu_result[1:0];
          state_d  = WAIT_LOAD;
        end else if (xfer) begin
          en_d   = mem_rd_we && (mem_rd != '0);
          dest_d = mem_rd;
          data_d = nl_data;
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          en_d    = rd_we_q && (rd_q != '0);
          dest_d  = rd_q;
          data_d  = ld_data;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rd_we_q  <= 1'b0;
      rd_q     <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      en_q     <= 1'b0;
      dest_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_we_q  <= rd_we_d;
      rd_q     <= rd_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      en_q     <= en_d;
      dest_q   <= dest_d;
      data_q   <= data_d;
    end
  end

  assign reg_write_en   = en_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;

`ifdef RISCV_WB_INSTRET_EN
  // Silent completions (rd==0, rd_we==0) still retire.
  logic        complete;
  logic [63:0] instret_q, instret_d;

  assign complete = ((state_q == IDLE) && xfer && !is_load)
                 || ((state_q == WAIT_LOAD) && dmem_rvalid);

  always_comb begin
    instret_d = instret_q;
    if (complete) instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule
